// File: rtl/sipo_word_rx_pkg.sv
// Constants shared by the serializer and this receiver so both ends agree on the word width.
package sipo_word_rx_pkg;

    localparam int unsigned SipoWordWidth = 32;

endpackage

// File: rtl/sipo_shift_core.sv
// Bit collector: shifts serial bits MSB-first and flags the cycle that completes a word.
module sipo_shift_core
    import sipo_word_rx_pkg::*;
#(
    parameter int unsigned N  = SipoWordWidth,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sin,
    input  logic          sin_en,
    input  logic          sof,
    output logic          word_done,
    output logic [N-1:0]  word,
    output logic [CW-1:0] cnt
);

    // Only N-1 bits are stored; the final bit is taken live from sin on the completion cycle.
    logic [N-2:0]  sr_q, sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_bit;

    assign last_bit  = (cnt_q == CW'(N - 1));
    assign word_done = sin_en && !sof && last_bit;
    assign word      = {sr_q, sin};
    assign cnt       = cnt_q;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (sof) begin
            // Realign: with a strobe, the current bit becomes bit 0 of the new word.
            sr_d = '0;
            if (sin_en) begin
                sr_d[0] = sin;
                cnt_d   = CW'(1);
            end else begin
                cnt_d   = '0;
            end
        end else if (sin_en) begin
            sr_d  = word[N-2:0];
            cnt_d = last_bit ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sipo_word_rx.sv
// Serial word receiver: shift core plus a one-entry valid/ready holding register with overrun flag.
module sipo_word_rx
    import sipo_word_rx_pkg::*;
#(
    parameter int unsigned N  = SipoWordWidth,
    parameter int unsigned CW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          sin,
    input  logic          sin_en,
    input  logic          sof,
    output logic [N-1:0]  dout,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [CW-1:0] bit_cnt,
    output logic          overrun,
    input  logic          ovr_clr
);

    logic          word_done;
    logic [N-1:0]  word;
    logic [N-1:0]  hold_q, hold_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          load, drop, read;

    sipo_shift_core #(
        .N  (N),
        .CW (CW)
    ) u_core (
        .clk       (clk),
        .reset     (reset),
        .sin       (sin),
        .sin_en    (sin_en),
        .sof       (sof),
        .word_done (word_done),
        .word      (word),
        .cnt       (bit_cnt)
    );

    assign read = valid_q && dout_ready;
    // A completing word may replace the held one only if that one is being read this cycle.
    assign load = word_done && (!valid_q || dout_ready);
    assign drop = word_done && valid_q && !dout_ready;

    always_comb begin
        hold_d    = hold_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (load) begin
            hold_d  = word;
            valid_d = 1'b1;
        end else if (read) begin
            valid_d = 1'b0;
        end
        // Set beats clear when both happen in the same cycle.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign dout       = hold_q;
    assign dout_valid = valid_q;
    assign overrun    = overrun_q;

endmodule
